// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory reads, and
// loads the IF/ID register (instr_id/npc_id/valid_id) consumed by decode.
// Latency: a word returned with ihit at edge N appears on instr_id after edge N.
// Backpressure: stall holds the PC and IF/ID; a miss (ihit=0) holds the PC and
// inserts bubbles. A redirect during a miss parks its target until the
// outstanding read returns. After HALT the stage is idle until reset.
//
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   ihit, imemload       memory response for the current imemaddr
//   imemREN, imemaddr    memory request (imemaddr is always the PC)
//   stall                hazard-unit hold of PC and IF/ID
//   redirect_valid/_pc   downstream-resolved control transfer
//   halt_in              decode has seen HALT
//   instr_id, npc_id,    IF/ID register; valid_id=0 marks a bubble
//   valid_id
//   halted               fetch has stopped permanently

module fetch_stage #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ihit,
   input  logic [31:0] imemload,
   output logic        imemREN,
   output logic [31:0] imemaddr,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt_in,
   output logic [31:0] instr_id,
   output logic [31:0] npc_id,
   output logic        valid_id,
   output logic        halted
);

   localparam logic [1:0] FETCH  = 2'd0;
   localparam logic [1:0] SQUASH = 2'd1;
   localparam logic [1:0] HALTED = 2'd2;

   logic [1:0]  state_q,    state_d;
   logic [31:0] pc_q,       pc_d;
   logic [31:0] pend_pc_q,  pend_pc_d;
   logic [31:0] instr_id_q, instr_id_d;
   logic [31:0] npc_id_q,   npc_id_d;
   logic        valid_id_q, valid_id_d;

   logic [31:0] redir_tgt;
   logic [31:0] pc_plus4;
   logic        bubble;

   // Targets are word aligned; the low two bits of a redirect are dropped.
   assign redir_tgt = {redirect_pc[31:2], 2'b00};
   assign pc_plus4  = pc_q + 32'd4;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_pc_d  = pend_pc_q;
      instr_id_d = instr_id_q;
      npc_id_d   = npc_id_q;
      valid_id_d = valid_id_q;
      bubble     = 1'b0;

      case (state_q)
         FETCH: begin
            if (halt_in) begin
               state_d = HALTED;
               bubble  = 1'b1;
            end else if (redirect_valid && ihit) begin
               pc_d   = redir_tgt;
               bubble = 1'b1;
            end else if (redirect_valid) begin
               // Read still outstanding: keep imemaddr stable and park the
               // target until the memory answers.
               pend_pc_d = redir_tgt;
               state_d   = SQUASH;
               bubble    = 1'b1;
            end else if (stall) begin
               // Hold everything; any word returned now is refetched later.
               state_d = FETCH;
            end else if (ihit) begin
               pc_d       = pc_plus4;
               instr_id_d = imemload;
               npc_id_d   = pc_plus4;
               valid_id_d = 1'b1;
            end else begin
               bubble = 1'b1;
            end
         end

         SQUASH: begin
            // The outstanding read belongs to the wrong path: never deliver it.
            bubble = 1'b1;
            if (halt_in) begin
               state_d = HALTED;
            end else if (redirect_valid) begin
               pend_pc_d = redir_tgt;
               if (ihit) begin
                  pc_d    = redir_tgt;
                  state_d = FETCH;
               end
            end else if (ihit) begin
               pc_d    = pend_pc_q;
               state_d = FETCH;
            end
         end

         HALTED: begin
            bubble = 1'b1;
         end

         default: begin
            // Unreachable encoding: recover into a clean fetch.
            state_d = FETCH;
            bubble  = 1'b1;
         end
      endcase

      if (bubble) begin
         instr_id_d = 32'h0;
         npc_id_d   = 32'h0;
         valid_id_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q    <= FETCH;
         pc_q       <= PC_INIT;
         pend_pc_q  <= 32'h0;
         instr_id_q <= 32'h0;
         npc_id_q   <= 32'h0;
         valid_id_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pend_pc_q  <= pend_pc_d;
         instr_id_q <= instr_id_d;
         npc_id_q   <= npc_id_d;
         valid_id_q <= valid_id_d;
      end
   end

   // Request side is decoded from state only; no input reaches an output
   // combinationally.
   assign imemREN  = (state_q != HALTED);
   assign imemaddr = pc_q;
   assign halted   = (state_q == HALTED);

   assign instr_id = instr_id_q;
   assign npc_id   = npc_id_q;
   assign valid_id = valid_id_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        ihit;
   logic [31:0] imemload;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt_in;
   logic [31:0] instr_id;
   logic [31:0] npc_id;
   logic        valid_id;
   logic        halted;

   int vectors = 0;
   int fails   = 0;

   fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
      .CLK(CLK), .nRST(nRST),
      .ihit(ihit), .imemload(imemload),
      .imemREN(imemREN), .imemaddr(imemaddr),
      .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halt_in(halt_in),
      .instr_id(instr_id), .npc_id(npc_id), .valid_id(valid_id),
      .halted(halted)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then sample 1 time unit later.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] npc,
                           input logic vld, input logic [31:0] addr);
      chk({tag, ".instr"}, instr_id, ins);
      chk({tag, ".npc"},   npc_id,   npc);
      chk({tag, ".valid"}, {31'b0, valid_id}, {31'b0, vld});
      chk({tag, ".addr"},  imemaddr, addr);
   endtask

   task automatic drive(input logic hit, input logic [31:0] load, input logic stl,
                        input logic rv, input logic [31:0] rpc, input logic hlt);
      ihit           = hit;
      imemload       = load;
      stall          = stl;
      redirect_valid = rv;
      redirect_pc    = rpc;
      halt_in        = hlt;
   endtask

   initial begin
      nRST = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      // Reset state
      chk_ifid("rst", 32'h0, 32'h0, 1'b0, 32'h0);
      chk("rst.halted", {31'b0, halted}, 32'd0);
      tick();
      nRST = 1'b1;
      #1;
      chk("rst.ren", {31'b0, imemREN}, 32'd1);

      // Zero-wait sequential fetch
      drive(1'b1, 32'h2001_0001, 1'b0, 1'b0, 32'h0, 1'b0);
      tick(); chk_ifid("seq0", 32'h2001_0001, 32'h4, 1'b1, 32'h4);
      imemload = 32'h2002_0002;
      tick(); chk_ifid("seq1", 32'h2002_0002, 32'h8, 1'b1, 32'h8);
      imemload = 32'h2003_0003;
      tick(); chk_ifid("seq2", 32'h2003_0003, 32'hC, 1'b1, 32'hC);
      imemload = 32'h2004_000C;
      tick(); chk_ifid("seq3", 32'h2004_000C, 32'h10, 1'b1, 32'h10);

      // Three-cycle miss at 0x10
      drive(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick(); chk_ifid($sformatf("miss%0d", i), 32'h0, 32'h0, 1'b0, 32'h10);
      end
      drive(1'b1, 32'hAAAA_0010, 1'b0, 1'b0, 32'h0, 1'b0);
      tick(); chk_ifid("misshit", 32'hAAAA_0010, 32'h14, 1'b1, 32'h14);

      // Redirect with hit, unaligned target
      drive(1'b1, 32'h5555_5555, 1'b0, 1'b1, 32'h47, 1'b0);
      tick(); chk_ifid("rdh", 32'h0, 32'h0, 1'b0, 32'h44);
      drive(1'b1, 32'hBBBB_0044, 1'b0, 1'b0, 32'h0, 1'b0);
      tick(); chk_ifid("rdh.next", 32'hBBBB_0044, 32'h48, 1'b1, 32'h48);

      // Redirect during a miss, newer redirect overrides, stale word dropped
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 1'b0);
      tick(); chk_ifid("sq0", 32'h0, 32'h0, 1'b0, 32'h48);
      drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 1'b0);
      tick(); chk_ifid("sq1", 32'h0, 32'h0, 1'b0, 32'h48);
      drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0);
      tick(); chk_ifid("sq.drop", 32'h0, 32'h0, 1'b0, 32'h200);
      imemload = 32'hCCCC_0200;
      tick(); chk_ifid("sq.resume", 32'hCCCC_0200, 32'h204, 1'b1, 32'h204);

      // Stall with a concurrent hit at 0x20
      drive(1'b1, 32'h0, 1'b0, 1'b1, 32'h1D, 1'b0);
      tick(); chk_ifid("st.rd", 32'h0, 32'h0, 1'b0, 32'h1C);
      drive(1'b1, 32'h1111_001C, 1'b0, 1'b0, 32'h0, 1'b0);
      tick(); chk_ifid("st.pre", 32'h1111_001C, 32'h20, 1'b1, 32'h20);
      drive(1'b1, 32'h2222_0020, 1'b1, 1'b0, 32'h0, 1'b0);
      tick(); chk_ifid("st0", 32'h1111_001C, 32'h20, 1'b1, 32'h20);
      tick(); chk_ifid("st1", 32'h1111_001C, 32'h20, 1'b1, 32'h20);
      stall = 1'b0;
      tick(); chk_ifid("st.rel", 32'h2222_0020, 32'h24, 1'b1, 32'h24);

      // PC wrap at the top of the address space
      drive(1'b1, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
      tick(); chk_ifid("wr.rd", 32'h0, 32'h0, 1'b0, 32'hFFFF_FFFC);
      drive(1'b1, 32'h3333_3333, 1'b0, 1'b0, 32'h0, 1'b0);
      tick(); chk_ifid("wrap", 32'h3333_3333, 32'h0, 1'b1, 32'h0);
      imemload = 32'h4444_4444;
      tick(); chk_ifid("wrap.n", 32'h4444_4444, 32'h4, 1'b1, 32'h4);

      // HALT is absorbing
      drive(1'b1, 32'h6666_6666, 1'b0, 1'b0, 32'h0, 1'b1);
      tick();
      chk_ifid("hlt", 32'h0, 32'h0, 1'b0, 32'h4);
      chk("hlt.halted", {31'b0, halted}, 32'd1);
      chk("hlt.ren", {31'b0, imemREN}, 32'd0);
      drive(1'b1, 32'h7777_7777, 1'b0, 1'b1, 32'h80, 1'b0);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk_ifid($sformatf("hlt.ign%0d", i), 32'h0, 32'h0, 1'b0, 32'h4);
         chk($sformatf("hlt.ign%0d.halted", i), {31'b0, halted}, 32'd1);
      end
      // Asynchronous reset mid-HALTED
      nRST = 1'b0;
      #1;
      chk("hrst.addr", imemaddr, 32'h0);
      chk("hrst.halted", {31'b0, halted}, 32'd0);
      chk("hrst.ren", {31'b0, imemREN}, 32'd1);
      tick();
      nRST = 1'b1;

      // Reset while parked in SQUASH discards the pending target
      drive(1'b1, 32'h8888_0000, 1'b0, 1'b0, 32'h0, 1'b0);
      tick(); chk_ifid("sr.pre", 32'h8888_0000, 32'h4, 1'b1, 32'h4);
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h300, 1'b0);
      tick(); chk_ifid("sr.sq", 32'h0, 32'h0, 1'b0, 32'h4);
      nRST = 1'b0;
      #1;
      chk_ifid("sr.rst", 32'h0, 32'h0, 1'b0, 32'h0);
      tick();
      nRST = 1'b1;
      drive(1'b1, 32'h9999_0000, 1'b0, 1'b0, 32'h0, 1'b0);
      tick(); chk_ifid("sr.post", 32'h9999_0000, 32'h4, 1'b1, 32'h4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
